// File: rtl/parity3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : parity3_pkg                                                   |
// | Description : Shared state encoding, default sizes and helpers for the      |
// |               3-bit-beat frame parity checker.                              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package parity3_pkg;

    localparam int MAX_BEATS_DEF = 16;
    localparam int CNT_W_DEF     = 5;
    localparam int STAT_W        = 16;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_ACCUM  = 3'd1;
    localparam state_t c_ST_PARITY = 3'd2;
    localparam state_t c_ST_DRAIN  = 3'd3;
    localparam state_t c_ST_REPORT = 3'd4;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity3_frame_checker_xor3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xor3                                                          |
// | Description : Three-input XOR gate cell used for per-beat reduction.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module xor3 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_y
);

    assign o_y = i_a ^ i_b ^ i_c;

endmodule
`default_nettype wire

// File: rtl/parity3_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : parity3_frame_checker                                         |
// | Description : Accumulates per-beat XOR over a frame of 3-bit beats, checks  |
// |               it against a trailing parity beat and reports error,          |
// |               overflow and framing status over valid/ready.                 |
// |               Define PARITY3_STATS_EN for frame/error statistic counters.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module parity3_frame_checker
    import parity3_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ODD       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_bits,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par_err,
    output logic              out_ovf,
    output logic              out_fmt_err,
    output logic [CNT_W-1:0]  out_beats
`ifdef PARITY3_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
    localparam logic             c_ODD = (ODD != 0);

    state_t           r_state,   w_state_nxt;
    logic             r_acc,     w_acc_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic             r_par_err, w_par_err_nxt;
    logic             r_ovf,     w_ovf_nxt;
    logic             r_fmt_err, w_fmt_err_nxt;
    logic             w_x3;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;

    xor3 u_xor3 (
        .i_a (in_bits[2]),
        .i_b (in_bits[1]),
        .i_c (in_bits[0]),
        .o_y (w_x3)
    );

    assign in_ready  = rst_n && (r_state != c_ST_REPORT);
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = (r_cnt == c_MAX) ? r_cnt : r_cnt + c_ONE;

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_par_err_nxt = r_par_err;
        w_ovf_nxt     = r_ovf;
        w_fmt_err_nxt = r_fmt_err;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_acc_nxt     = w_x3;
                    w_cnt_nxt     = c_ONE;
                    w_par_err_nxt = 1'b0;
                    w_ovf_nxt     = 1'b0;
                    w_fmt_err_nxt = 1'b0;
                    if (in_last) begin
                        w_state_nxt = c_ST_PARITY;
                    end else if (c_MAX == c_ONE) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = c_ST_DRAIN;
                    end else begin
                        w_state_nxt = c_ST_ACCUM;
                    end
                end
            end
            c_ST_ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = r_acc ^ w_x3;
                    w_cnt_nxt = w_cnt_inc;
                    // A last beat landing exactly on MAX_BEATS is still a legal frame
                    if (in_last) begin
                        w_state_nxt = c_ST_PARITY;
                    end else if (w_cnt_inc == c_MAX) begin
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = c_ST_DRAIN;
                    end
                end
            end
            c_ST_PARITY: begin
                if (w_accept) begin
                    w_par_err_nxt = r_acc ^ in_bits[0] ^ c_ODD;
                    if (in_last) begin
                        w_state_nxt = c_ST_REPORT;
                    end else begin
                        w_fmt_err_nxt = 1'b1;
                        w_state_nxt   = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (w_accept && in_last) begin
                    w_state_nxt = c_ST_REPORT;
                end
            end
            c_ST_REPORT: begin
                if (out_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_acc     <= 1'b0;
            r_cnt     <= '0;
            r_par_err <= 1'b0;
            r_ovf     <= 1'b0;
            r_fmt_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_par_err <= w_par_err_nxt;
            r_ovf     <= w_ovf_nxt;
            r_fmt_err <= w_fmt_err_nxt;
        end
    end

    assign out_valid   = (r_state == c_ST_REPORT);
    assign out_par_err = r_par_err;
    assign out_ovf     = r_ovf;
    assign out_fmt_err = r_fmt_err;
    assign out_beats   = r_cnt;

`ifdef PARITY3_STATS_EN
    logic [STAT_W-1:0] r_stat_frames;
    logic [STAT_W-1:0] r_stat_errs;
    logic              w_rpt_hs;

    assign w_rpt_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_frames <= '0;
            r_stat_errs   <= '0;
        end else if (w_rpt_hs) begin
            r_stat_frames <= sat_inc(r_stat_frames);
            if (r_par_err || r_ovf || r_fmt_err) begin
                r_stat_errs <= sat_inc(r_stat_errs);
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_errs   = r_stat_errs;
`else
    // Statistics counters are absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity3_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_parity3_frame_checker                                      |
// | Description : Self-checking bench for parity3_frame_checker (MAX_BEATS=4    |
// |               main instance, ODD=1 side instance).                          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_parity3_frame_checker;
    import parity3_pkg::*;

    localparam int c_MAX = 4;
    localparam int c_CW  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_bits = 3'b000;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_par_err;
    logic            out_ovf;
    logic            out_fmt_err;
    logic [c_CW-1:0] out_beats;

    logic            odd_in_valid = 1'b0;
    logic            odd_in_ready;
    logic [2:0]      odd_in_bits = 3'b000;
    logic            odd_in_last = 1'b0;
    logic            odd_out_valid;
    logic            odd_out_ready = 1'b0;
    logic            odd_out_par_err;
    logic            odd_out_ovf;
    logic            odd_out_fmt_err;
    logic [4:0]      odd_out_beats;

`ifdef PARITY3_STATS_EN
    logic [STAT_W-1:0] stat_frames, stat_errs;
    logic [STAT_W-1:0] odd_stat_frames, odd_stat_errs;
`endif

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_errs = 0;

    always #5 clk = ~clk;

    parity3_frame_checker #(.MAX_BEATS(c_MAX), .CNT_W(c_CW), .ODD(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_par_err(out_par_err),
        .out_ovf(out_ovf), .out_fmt_err(out_fmt_err), .out_beats(out_beats)
`ifdef PARITY3_STATS_EN
        , .stat_frames(stat_frames), .stat_errs(stat_errs)
`endif
    );

    parity3_frame_checker #(.MAX_BEATS(16), .CNT_W(5), .ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n),
        .in_valid(odd_in_valid), .in_ready(odd_in_ready), .in_bits(odd_in_bits),
        .in_last(odd_in_last), .out_valid(odd_out_valid), .out_ready(odd_out_ready),
        .out_par_err(odd_out_par_err), .out_ovf(odd_out_ovf),
        .out_fmt_err(odd_out_fmt_err), .out_beats(odd_out_beats)
`ifdef PARITY3_STATS_EN
        , .stat_frames(odd_stat_frames), .stat_errs(odd_stat_errs)
`endif
    );

    typedef struct {
        int         n;
        logic [23:0] d;
        logic [2:0] p;
        bit         p_last;
        int         extra;
        logic       par;
        logic       ovf;
        logic       fmt;
        int         beats;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: parity is the weight of all data bits plus the parity bit.
    function automatic void model(input int n, input logic [23:0] d, input logic [2:0] p,
                                  input bit p_last, input int odd, input int maxb,
                                  output logic par, output logic ovf, output logic fmt,
                                  output int beats);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += $countones(d[i*3 +: 3]);
        if (n > maxb) begin
            par = 1'b0; ovf = 1'b1; fmt = 1'b0; beats = maxb;
        end else begin
            par = 1'((ones + int'(p[0]) + odd) % 2);
            ovf = 1'b0; fmt = !p_last; beats = n;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [2:0] bits, input logic last);
        int waited = 0;
        in_bits = bits; in_last = last; in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [23:0] d, input logic [2:0] p,
                              input bit p_last, input int extra, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            send_beat(d[i*3 +: 3], 1'(i == n - 1));
        end
        if (n <= c_MAX) begin
            send_beat(p, p_last);
            if (!p_last) begin
                for (int j = 0; j < extra; j++) send_beat(3'($urandom), 1'b0);
                send_beat(3'($urandom), 1'b1);
            end
        end
    endtask

    task automatic check_report(input string name, input logic par, input logic ovf,
                                input logic fmt, input int beats, input int hold);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_ready_low"}, 32'(in_ready), 32'd0);
        chk({name, "_par_err"}, 32'(out_par_err), 32'(par));
        chk({name, "_ovf"}, 32'(out_ovf), 32'(ovf));
        chk({name, "_fmt_err"}, 32'(out_fmt_err), 32'(fmt));
        chk({name, "_beats"}, 32'(out_beats), 32'(beats));
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({name, "_hold"},
                {24'd0, out_valid, in_ready, out_par_err, out_ovf, out_fmt_err, out_beats},
                {24'd0, 1'b1, 1'b0, par, ovf, fmt, 3'(beats)});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_frames++;
        if (par || ovf || fmt) exp_errs++;
        chk({name, "_drop"}, 32'(out_valid), 32'd0);
        chk({name, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({name, "_held_beats"}, 32'(out_beats), 32'(beats));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic par, ovf, fmt;
        int   beats, n, kind, extra;
        bit   p_last;
        logic [23:0] d;
        logic [2:0]  p;

        tbl[0] = '{3, 24'({3'b111, 3'b011, 3'b001}), 3'b000, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3};
        tbl[1] = '{3, 24'({3'b111, 3'b011, 3'b001}), 3'b001, 1'b1, 0, 1'b1, 1'b0, 1'b0, 3};
        tbl[2] = '{6, 24'({6{3'b001}}),              3'b000, 1'b1, 0, 1'b0, 1'b1, 1'b0, 4};
        tbl[3] = '{2, 24'({3'b010, 3'b001}),         3'b000, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2};
        tbl[4] = '{1, 24'(3'b110),                   3'b001, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1};
        tbl[5] = '{4, 24'({4{3'b001}}),              3'b000, 1'b1, 0, 1'b0, 1'b0, 1'b0, 4};
        tbl[6] = '{5, 24'({5{3'b111}}),              3'b000, 1'b1, 0, 1'b0, 1'b1, 1'b0, 4};
        tbl[7] = '{3, 24'({3'b000, 3'b000, 3'b100}), 3'b000, 1'b0, 2, 1'b1, 1'b0, 1'b1, 3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_flags", 32'({out_par_err, out_ovf, out_fmt_err}), 32'd0);
        chk("rst_beats", 32'(out_beats), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].n, tbl[i].d, tbl[i].p, tbl[i].p_last, tbl[i].extra, 1'b0);
            check_report($sformatf("vec%0d", i), tbl[i].par, tbl[i].ovf, tbl[i].fmt,
                         tbl[i].beats, 0);
        end

        // Backpressure: report held for 10 cycles
        send_frame(tbl[0].n, tbl[0].d, tbl[0].p, 1'b1, 0, 1'b0);
        check_report("bp", 1'b0, 1'b0, 1'b0, 3, 10);

        // Randomized frames against the frame-level model
        for (int f = 0; f < 30; f++) begin
            kind  = $urandom_range(0, 2);
            extra = 0;
            p_last = 1'b1;
            if (kind == 2) n = $urandom_range(5, 7);
            else n = $urandom_range(1, 4);
            if (kind == 1) begin
                p_last = 1'b0;
                extra  = $urandom_range(0, 2);
            end
            d = 24'($urandom);
            p = 3'($urandom);
            model(n, d, p, p_last, 0, c_MAX, par, ovf, fmt, beats);
            send_frame(n, d, p, p_last, extra, 1'b1);
            check_report($sformatf("rand%0d", f), par, ovf, fmt, beats, $urandom_range(0, 3));
        end

`ifdef PARITY3_STATS_EN
        chk("stat_frames_run", 32'(stat_frames), 32'(exp_frames));
        chk("stat_errs_run", 32'(stat_errs), 32'(exp_errs));
`endif

        // Reset mid-frame, with a competing last beat during reset
        send_beat(3'b001, 1'b0);
        send_beat(3'b010, 1'b0);
        rst_n = 1'b0; in_valid = 1'b1; in_bits = 3'b001; in_last = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_beats", 32'(out_beats), 32'd0);
        chk("midrst_flags", 32'({out_par_err, out_ovf, out_fmt_err}), 32'd0);
        in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b1;
        exp_frames = 0; exp_errs = 0;
        #1;
        chk("midrst_rel_ready", 32'(in_ready), 32'd1);
        idle(2);
        chk("midrst_no_report", 32'(out_valid), 32'd0);

        // Three frames after reset, one erroneous
        send_frame(1, 24'(3'b011), 3'b000, 1'b1, 0, 1'b0);
        check_report("post_rst", 1'b0, 1'b0, 1'b0, 1, 0);
        send_frame(tbl[1].n, tbl[1].d, tbl[1].p, 1'b1, 0, 1'b0);
        check_report("post_bad", 1'b1, 1'b0, 1'b0, 3, 0);
        send_frame(tbl[0].n, tbl[0].d, tbl[0].p, 1'b1, 0, 1'b0);
        check_report("post_good", 1'b0, 1'b0, 1'b0, 3, 0);
`ifdef PARITY3_STATS_EN
        chk("stat_frames_3", 32'(stat_frames), 32'd3);
        chk("stat_errs_1", 32'(stat_errs), 32'd1);
`endif

        // Odd-parity instance: same data, parity bit 1 is correct
        for (int i = 0; i < 4; i++) begin
            odd_in_bits = (i == 0) ? 3'b001 : (i == 1) ? 3'b011 : (i == 2) ? 3'b111 : 3'b001;
            odd_in_last = (i >= 2);
            odd_in_valid = 1'b1;
            chk("odd_in_ready", 32'(odd_in_ready), 32'd1);
            @(posedge clk); #1;
            odd_in_valid = 1'b0;
        end
        chk("odd_valid", 32'(odd_out_valid), 32'd1);
        chk("odd_par_err", 32'(odd_out_par_err), 32'd0);
        chk("odd_beats", 32'(odd_out_beats), 32'd3);
        odd_out_ready = 1'b1;
        @(posedge clk); #1;
        odd_out_ready = 1'b0;
        chk("odd_drop", 32'(odd_out_valid), 32'd0);
`ifdef PARITY3_STATS_EN
        chk("odd_stat_frames", 32'(odd_stat_frames), 32'd1);
        chk("odd_stat_errs", 32'(odd_stat_errs), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
